// File: rtl/uart_rx_if.sv
// Consumer-side handshake bundle of uart_rx: received byte, level-held ready, status pulses.
// The parity_error signal exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       rx_busy;
  logic       frame_error;
  logic       overrun_error;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif
  logic       read_data;

  modport master (
    output rx_data, data_ready, rx_busy, frame_error, overrun_error,
`ifdef UART_RX_PARITY_EN
    output parity_error,
`endif
    input  read_data
  );

  modport slave (
    input  rx_data, data_ready, rx_busy, frame_error, overrun_error,
`ifdef UART_RX_PARITY_EN
    input  parity_error,
`endif
    output read_data
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with level-held data_ready handshake and false-start/framing/overrun flags.
// Define UART_RX_PARITY_EN to add a parity bit (sense set by PARITY_ODD) and parity_error.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx_in,
  uart_rx_if.master bus
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    ACCEPT
  } state_t;

  state_t      state;
  logic [1:0]  sync_q;
  logic [1:0]  primed_q;
  logic        rx_s;
  logic [CW-1:0] bit_cnt;
  logic [2:0]  idx;
  logic [7:0]  shift_reg;
  logic        stop_ok;
  logic [7:0]  rx_data_q;
  logic        data_ready_q;
  logic        busy_q;
  logic        frame_error_q;
  logic        overrun_q;
`ifdef UART_RX_PARITY_EN
  logic        par_bad;
  logic        parity_error_q;
`else
  logic        unused_parity_sense;
  assign unused_parity_sense = PARITY_ODD;
`endif

  assign rx_s = sync_q[1];

  // NOTE: every register here is state, so each is updated with <= inside one clocked block;
  // blocking assignments would make later reads in the same block see next-cycle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= 2'b11;
      primed_q      <= 2'b00;
      state         <= WAIT_IDLE;
      bit_cnt       <= '0;
      idx           <= '0;
      shift_reg     <= '0;
      stop_ok       <= 1'b0;
      rx_data_q     <= '0;
      data_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad        <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      sync_q        <= {sync_q[0], rx_in};
      primed_q      <= {primed_q[0], 1'b1};
      bit_cnt       <= bit_cnt + CW'(1);
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= 1'b0;
`endif
      if (bus.read_data) data_ready_q <= 1'b0;

      case (state)
        // The synchronizer resets high, so trust rx_s only once real line samples have filled it;
        // otherwise a line held low through reset would look idle for two cycles.
        WAIT_IDLE: if (rx_s && primed_q[1]) state <= IDLE;
        IDLE: if (!rx_s) begin
          state   <= START;
          bit_cnt <= '0;
          busy_q  <= 1'b1;
        end
        START: if (bit_cnt == CW'(HALF - 1)) begin
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state   <= DATA;
            bit_cnt <= '0;
            idx     <= '0;
          end
        end
        DATA: if (bit_cnt == CW'(CLKS_PER_BIT - 1)) begin
          bit_cnt        <= '0;
          shift_reg[idx] <= rx_s;
          idx            <= idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (bit_cnt == CW'(CLKS_PER_BIT - 1)) begin
          bit_cnt <= '0;
          par_bad <= ((^shift_reg) ^ rx_s) != PARITY_ODD;
          state   <= STOP;
        end
`endif
        STOP: if (bit_cnt == CW'(CLKS_PER_BIT - 1)) begin
          stop_ok <= rx_s;
          state   <= ACCEPT;
        end
        ACCEPT: begin
          // Exactly one outcome per frame: parity beats framing beats overrun.
          busy_q <= 1'b0;
          state  <= stop_ok ? IDLE : WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          if (par_bad) parity_error_q <= 1'b1;
          else
`endif
          if (!stop_ok) frame_error_q <= 1'b1;
          else if (!data_ready_q || bus.read_data) begin
            rx_data_q    <= shift_reg;
            data_ready_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.data_ready    = data_ready_q;
  assign bus.rx_busy       = busy_q;
  assign bus.frame_error   = frame_error_q;
  assign bus.overrun_error = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error  = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are driven bit by bit and checked against a
// frame-level reference model (byte / stop / parity outcome -> data, ready and error counts).
module tb_uart_rx;
  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = 3 + H + (9 + P) * C;

  logic clk = 1'b0;
  logic reset;
  logic rx_in;
  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .rx_in (rx_in),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int   fe_cnt = 0, oe_cnt = 0, pe_cnt = 0, busy_rises = 0;
  int   rise_cyc = -1, busy_fall_cyc = -1;
  logic prev_ready = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    fe_cnt = fe_cnt + int'(bus.frame_error);
    oe_cnt = oe_cnt + int'(bus.overrun_error);
`ifdef UART_RX_PARITY_EN
    pe_cnt = pe_cnt + int'(bus.parity_error);
`endif
    if (bus.data_ready && !prev_ready) rise_cyc = cyc;
    if (bus.rx_busy && !prev_busy) busy_rises = busy_rises + 1;
    if (!bus.rx_busy && prev_busy) busy_fall_cyc = cyc;
    prev_ready = bus.data_ready;
    prev_busy  = bus.rx_busy;
  end

  // Reference model state
  logic [7:0] m_data;
  logic       m_ready;
  int         e_fe = 0, e_oe = 0, e_pe = 0;
  int         n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok,
                             input logic rd);
    if (!par_ok) e_pe++;
    else if (!stop_ok) e_fe++;
    else if (m_ready && !rd) e_oe++;
    else begin
      m_data  = d;
      m_ready = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    #1;
    check({tag, "_data"},  {24'd0, bus.rx_data}, {24'd0, m_data});
    check({tag, "_ready"}, {31'd0, bus.data_ready}, {31'd0, m_ready});
    check({tag, "_ferr"},  fe_cnt, e_fe);
    check({tag, "_oerr"},  oe_cnt, e_oe);
    check({tag, "_perr"},  pe_cnt, e_pe);
  endtask

  task automatic idle_cycles(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (C) @(negedge clk);
  endtask

  // Called on a falling edge; t0 is the rising edge that first captures the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip_par,
                            output int t0);
    t0 = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ flip_par);
`else
    if (flip_par) rx_in = 1'b1;
`endif
    drive_bit(stop_bit);
  endtask

  task automatic do_read();
    bus.read_data = 1'b1;
    @(negedge clk);
    bus.read_data = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    m_data  = 8'h00;
    m_ready = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, b0;
    logic [7:0] d;
    logic bad_stop, flip, was_ready;
    rx_in = 1'b1;
    bus.read_data = 1'b0;
    @(negedge clk);
    apply_reset();

    // Idle line after reset
    idle_cycles(100);
    check_state("reset");
    check("reset_busy", {31'd0, bus.rx_busy}, 32'd0);

    // Single frame: value, latency, busy fall, read handshake
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    model_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    idle_cycles(4);
    check_state("a5");
    check("a5_latency", rise_cyc, t0 + LAT);
    check("a5_busy_fall", busy_fall_cyc, t0 + LAT);
    do_read();
    #1 check("a5_read_clears", {31'd0, bus.data_ready}, 32'd0);

    // False start of 6 low cycles
    b0 = busy_rises;
    rx_in = 1'b0;
    repeat (6) @(negedge clk);
    idle_cycles(30);
    check("false_busy_pulse", busy_rises, b0 + 1);
    check("false_busy_low", {31'd0, bus.rx_busy}, 32'd0);
    check_state("false");

    // Framing error, then recovery
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    model_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    idle_cycles(10);
    check_state("ferr");
    send_frame(8'h81, 1'b1, 1'b0, t0);
    model_frame(8'h81, 1'b1, 1'b1, 1'b0);
    idle_cycles(4);
    check_state("after_ferr");
    do_read();

    // Back-to-back frames without a read: second byte overruns
    send_frame(8'h11, 1'b1, 1'b0, t0);
    model_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, t0);
    model_frame(8'h22, 1'b1, 1'b1, 1'b0);
    idle_cycles(4);
    check_state("b2b_overrun");
    do_read();

    // Back-to-back with read_data on the accept cycle of the second frame
    send_frame(8'h11, 1'b1, 1'b0, t0);
    model_frame(8'h11, 1'b1, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0, t0);
      begin
        repeat (LAT) @(negedge clk);
        bus.read_data = 1'b1;
        @(negedge clk);
        bus.read_data = 1'b0;
      end
    join
    model_frame(8'h22, 1'b1, 1'b1, 1'b1);
    idle_cycles(4);
    check_state("b2b_read");
    do_read();

    // Reset in the middle of 0xFF, line held low afterwards
    rx_in = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (H) @(negedge clk);
    rx_in = 1'b0;
    apply_reset();
    b0 = busy_rises;
    repeat (40) @(negedge clk);
    check("rst_mid_busy", {31'd0, bus.rx_busy}, 32'd0);
    check("rst_mid_no_start", busy_rises, b0);
    check_state("rst_mid");
    idle_cycles(10);
    send_frame(8'h5A, 1'b1, 1'b0, t0);
    model_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    idle_cycles(4);
    check_state("after_rst");
    do_read();
`ifdef UART_RX_PARITY_EN
    send_frame(8'h5A, 1'b1, 1'b1, t0);
    model_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    check_state("parity_flip");
`endif

    // Randomized frames, gaps, reads and error injection
    for (int n = 0; n < 24; n++) begin
      d        = 8'($urandom);
      bad_stop = ($urandom_range(0, 5) == 0);
      flip     = (P == 1) && ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) do_read();
      was_ready = m_ready;
      rise_cyc  = -1;
      send_frame(d, !bad_stop, flip, t0);
      model_frame(d, !bad_stop, !flip, 1'b0);
      check_state($sformatf("rnd%0d", n));
      if (!was_ready && !bad_stop && !flip)
        check($sformatf("rnd%0d_latency", n), rise_cyc, t0 + LAT);
      idle_cycles((bad_stop || flip) ? 4 + $urandom_range(0, 10) : $urandom_range(0, 20));
    end

    idle_cycles(4);
    check_state("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
